// File: rtl/lu_accum.sv
// lu_accum: pipelined set-coverage logic unit with a saturating hit counter.
// A frame starts with start_i in IDLE, which latches mode/mask/k. Each valid
// coverage vector is evaluated and registered (stage 1), then added to the
// hit count (stage 2). A valid last point ends the frame with a done strobe.
module lu_accum #(
    parameter int unsigned N_SETS = 3,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned K_W   = $clog2(N_SETS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        mode_i,
    input  logic [N_SETS-1:0] mask_i,
    input  logic [K_W-1:0]    k_i,
    input  logic              pt_valid_i,
    input  logic [N_SETS-1:0] covered_i,
    input  logic              pt_last_i,
    output logic              busy_o,
    output logic              hit_valid_o,
    output logic              hit_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              sat_o
);

    localparam logic [2:0] ModeAll     = 3'd0;
    localparam logic [2:0] ModeAny     = 3'd1;
    localparam logic [2:0] ModeOdd     = 3'd2;
    localparam logic [2:0] ModeExact   = 3'd3;
    localparam logic [2:0] ModeAtLeast = 3'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Number of set bits in a coverage vector.
    function automatic logic [K_W-1:0] popcount(input logic [N_SETS-1:0] v);
        logic [K_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < int'(N_SETS); i++) begin
            sum = sum + K_W'(v[i]);
        end
        return sum;
    endfunction

    // State and latched frame configuration.
    state_e            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [N_SETS-1:0] mask_q, mask_d;
    logic [K_W-1:0]    k_q, k_d;

    // Stage 1: registered per-point result.
    logic              hit_valid_q, hit_valid_d;
    logic              hit_q, hit_d;
    logic              last_q, last_d;

    // Stage 2: hit count and saturation flag.
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d;

    // Registered status outputs.
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_start;
    logic              accept_pt;
    logic              inc_req;
    logic [N_SETS-1:0] masked;
    logic [K_W-1:0]    pop;
    logic              hit_raw;

    // Evaluate the latched mode against the incoming coverage vector.
    always_comb begin
        masked  = covered_i & mask_q;
        pop     = popcount(masked);
        hit_raw = 1'b0;
        case (mode_q)
            ModeAll:     hit_raw = (masked == mask_q) && (mask_q != '0);
            ModeAny:     hit_raw = |masked;
            ModeOdd:     hit_raw = ^masked;
            ModeExact:   hit_raw = (pop == k_q);
            ModeAtLeast: hit_raw = (pop >= k_q);
            default:     hit_raw = 1'b0;
        endcase
    end

    // Frame sequencing: IDLE -> ACCUM on start, ACCUM -> DONE once stage 1 holds the last point.
    always_comb begin
        accept_start = (state_q == StIdle) && start_i;
        accept_pt    = (state_q == StAccum) && pt_valid_i;

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StAccum;
            StAccum: if (hit_valid_q && last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Configuration is captured only on an accepted start and held for the frame.
    always_comb begin
        mode_d = mode_q;
        mask_d = mask_q;
        k_d    = k_q;
        if (accept_start) begin
            mode_d = mode_i;
            mask_d = mask_i;
            k_d    = k_i;
        end
    end

    // Stage 1: register the evaluated point; points outside ACCUM leave no trace.
    always_comb begin
        hit_valid_d = accept_pt;
        hit_d       = accept_pt & hit_raw;
        last_d      = accept_pt & pt_last_i;
    end

    // Stage 2: accumulate hits while the frame is open; saturate at all-ones.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        // Points trailing the last one (still in ACCUM for a cycle) are not counted.
        inc_req = (state_q == StAccum) && hit_valid_q && hit_q;
        if (accept_start) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc_req) begin
            if (count_q == {CNT_W{1'b1}}) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // All state, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            mask_q      <= '0;
            k_q         <= '0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            last_q      <= 1'b0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            k_q         <= k_d;
            hit_valid_q <= hit_valid_d;
            hit_q       <= hit_d;
            last_q      <= last_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign hit_valid_o = hit_valid_q;
    assign hit_o       = hit_q;
    assign done_o      = done_q;
    assign count_o     = count_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_lu_accum.sv
// Bench for lu_accum: an 8-bit counter instance and a 4-bit counter instance
// share the stimulus; results are checked against a mode-rule reference model.
module tb_lu_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i = 1'b0;
    logic [2:0] mode_i = '0;
    logic [2:0] mask_i = '0;
    logic [1:0] k_i = '0;
    logic       pt_valid_i = 1'b0;
    logic [2:0] covered_i = '0;
    logic       pt_last_i = 1'b0;

    logic       busy_o, hit_valid_o, hit_o, done_o, sat_o;
    logic [7:0] count_o;
    logic       busy4, hv4, hit4, done4, sat4;
    logic [3:0] count4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lu_accum #(.N_SETS(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .mask_i(mask_i),
        .k_i(k_i), .pt_valid_i(pt_valid_i), .covered_i(covered_i), .pt_last_i(pt_last_i),
        .busy_o(busy_o), .hit_valid_o(hit_valid_o), .hit_o(hit_o), .done_o(done_o),
        .count_o(count_o), .sat_o(sat_o)
    );

    lu_accum #(.N_SETS(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .mask_i(mask_i),
        .k_i(k_i), .pt_valid_i(pt_valid_i), .covered_i(covered_i), .pt_last_i(pt_last_i),
        .busy_o(busy4), .hit_valid_o(hv4), .hit_o(hit4), .done_o(done4),
        .count_o(count4), .sat_o(sat4)
    );

    // Frame stimulus and what was observed while it ran.
    logic [2:0] f_cov[$];
    bit         f_v[$];
    bit         o_hv[$];
    logic       o_hit[$];
    int         o_lat;
    logic [7:0] o_cnt, o_cnt_start;
    logic       o_sat, o_sat_start;
    logic [3:0] o_cnt4, o_cnt4_start;
    logic       o_sat4, o_sat4_start;
    logic       o_busy_start, o_busy_end, o_done_end;

    // Reference: the mode rules applied directly to one coverage vector.
    function automatic bit model_hit(input logic [2:0] md, input logic [2:0] mk,
                                     input logic [1:0] kk, input logic [2:0] cov);
        logic [2:0] m;
        int pc;
        m = cov & mk;
        pc = $countones(m);
        case (md)
            3'd0: return (m == mk) && (mk != 3'b000);
            3'd1: return m != 3'b000;
            3'd2: return (pc % 2) == 1;
            3'd3: return pc == int'(kk);
            3'd4: return pc >= int'(kk);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_hits(input logic [2:0] md, input logic [2:0] mk,
                                      input logic [1:0] kk);
        int h;
        h = 0;
        foreach (f_cov[i]) if (f_v[i] && model_hit(md, mk, kk, f_cov[i])) h++;
        return h;
    endfunction

    // Drives one frame from f_cov/f_v (last entry is the last point) and records outputs.
    task automatic run_frame(input logic [2:0] md, input logic [2:0] mk, input logic [1:0] kk);
        int last_idx;
        o_hv.delete();
        o_hit.delete();
        o_lat = -1;
        last_idx = f_cov.size() - 1;
        @(negedge clk);
        start_i = 1'b1; mode_i = md; mask_i = mk; k_i = kk;
        @(negedge clk);
        start_i = 1'b0; mode_i = 3'($urandom); mask_i = 3'($urandom); k_i = 2'($urandom);
        o_busy_start = busy_o; o_cnt_start = count_o; o_sat_start = sat_o;
        o_cnt4_start = count4; o_sat4_start = sat4;
        foreach (f_cov[i]) begin
            pt_valid_i = f_v[i];
            covered_i = f_cov[i];
            if (i == last_idx) pt_last_i = 1'b1;
            else pt_last_i = f_v[i] ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            o_hv.push_back(hit_valid_o);
            o_hit.push_back(hit_o);
        end
        pt_valid_i = 1'b0; pt_last_i = 1'b0; covered_i = 3'($urandom);
        for (int c = 2; c <= 8 && o_lat < 0; c++) begin
            @(negedge clk);
            if (done_o) begin
                o_lat = c;
                o_cnt = count_o; o_sat = sat_o; o_cnt4 = count4; o_sat4 = sat4;
            end
        end
        @(negedge clk);
        o_busy_end = busy_o;
        o_done_end = done_o;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #5;
        n_total++;
        if ({busy_o, hit_valid_o, hit_o, done_o, sat_o, count_o} !== 13'd0)
            $display("FAIL reset_idle: got %b want 0", {busy_o, hit_valid_o, hit_o, done_o, sat_o, count_o});
        else n_pass++;
        n_total++;
        if ({busy4, hv4, hit4, done4, sat4, count4} !== 9'd0)
            $display("FAIL reset_idle4: got %b want 0", {busy4, hv4, hit4, done4, sat4, count4});
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        // Open a frame, feed hitting points without a last, then reset mid-frame.
        @(negedge clk);
        start_i = 1'b1; mode_i = 3'd4; mask_i = 3'b111; k_i = 2'd0;
        @(negedge clk);
        start_i = 1'b0; pt_valid_i = 1'b1; covered_i = 3'b101;
        repeat (3) @(negedge clk);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL midframe_busy: got %b want 1", busy_o);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy_o, hit_valid_o, hit_o, done_o, sat_o, count_o} !== 13'd0)
            $display("FAIL reset_midframe: got %b want 0", {busy_o, hit_valid_o, hit_o, done_o, sat_o, count_o});
        else n_pass++;
        pt_valid_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_total++;
            if ({done_o, busy_o, count_o} !== 10'd0)
                $display("FAIL reset_no_done c%0d: got done=%b busy=%b cnt=%0d want 0", c, done_o, busy_o, count_o);
            else n_pass++;
        end
    endtask

    task automatic test_legacy_mode4();
        logic [2:0] pts [6] = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b000, 3'b010};
        f_cov.delete(); f_v.delete();
        foreach (pts[i]) begin f_cov.push_back(pts[i]); f_v.push_back(1'b1); end
        run_frame(3'd3, 3'b111, 2'd2);
        n_total++;
        if (o_cnt !== 8'd3) $display("FAIL legacy_count: got %0d want 3", o_cnt);
        else n_pass++;
        n_total++;
        if (o_lat !== 2) $display("FAIL legacy_done_latency: got %0d want 2", o_lat);
        else n_pass++;
        n_total++;
        if (o_busy_start !== 1'b1) $display("FAIL legacy_busy_start: got %b want 1", o_busy_start);
        else n_pass++;
        n_total++;
        if ({o_busy_end, o_done_end} !== 2'b00)
            $display("FAIL legacy_end: got busy/done %b want 00", {o_busy_end, o_done_end});
        else n_pass++;
    endtask

    task automatic test_odd();
        logic [2:0] pts [4] = '{3'b100, 3'b110, 3'b010, 3'b001};
        logic [3:0] got;
        f_cov.delete(); f_v.delete();
        foreach (pts[i]) begin f_cov.push_back(pts[i]); f_v.push_back(1'b1); end
        run_frame(3'd2, 3'b110, 2'd0);
        got = {o_hit[0], o_hit[1], o_hit[2], o_hit[3]};
        n_total++;
        if (got !== 4'b1010) $display("FAIL odd_hits: got %b want 1010", got);
        else n_pass++;
        n_total++;
        if (o_cnt !== 8'd2) $display("FAIL odd_count: got %0d want 2", o_cnt);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int lens [2] = '{15, 20};
        foreach (lens[j]) begin
            f_cov.delete(); f_v.delete();
            for (int i = 0; i < lens[j]; i++) begin
                f_cov.push_back(3'($urandom)); f_v.push_back(1'b1);
            end
            run_frame(3'd4, 3'($urandom), 2'd0);
            n_total++;
            if ({o_cnt4, o_sat4} !== {4'd15, lens[j] > 15})
                $display("FAIL sat4_len%0d: got cnt=%0d sat=%b want cnt=15 sat=%b", lens[j], o_cnt4, o_sat4, lens[j] > 15);
            else n_pass++;
            n_total++;
            if ({o_cnt, o_sat} !== {8'(lens[j]), 1'b0})
                $display("FAIL sat8_len%0d: got cnt=%0d sat=%b want cnt=%0d sat=0", lens[j], o_cnt, o_sat, lens[j]);
            else n_pass++;
        end
        f_cov.delete(); f_v.delete();
        f_cov.push_back(3'b111); f_v.push_back(1'b1);
        run_frame(3'd5, 3'b111, 2'd0);
        n_total++;
        if ({o_cnt4_start, o_sat4_start, o_cnt_start, o_sat_start} !== 14'd0)
            $display("FAIL sat_clear_on_start: got cnt4=%0d sat4=%b cnt=%0d sat=%b want 0", o_cnt4_start, o_sat4_start, o_cnt_start, o_sat_start);
        else n_pass++;
    endtask

    task automatic test_ignore();
        logic [7:0] held;
        held = count_o;
        pt_valid_i = 1'b1; covered_i = 3'b111; pt_last_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (hit_valid_o !== 1'b0) $display("FAIL idle_pt_hv: got %b want 0", hit_valid_o);
            else n_pass++;
        end
        pt_valid_i = 1'b0; pt_last_i = 1'b0;
        n_total++;
        if (count_o !== held) $display("FAIL idle_pt_count: got %0d want %0d", count_o, held);
        else n_pass++;
        // ANY on set 0; a start mid-frame tries to switch to the always-miss mode.
        @(negedge clk);
        start_i = 1'b1; mode_i = 3'd1; mask_i = 3'b001; k_i = 2'd0;
        @(negedge clk);
        start_i = 1'b1; mode_i = 3'd5; mask_i = 3'b111;
        pt_valid_i = 1'b1; covered_i = 3'b001;
        @(negedge clk);
        start_i = 1'b0;
        n_total++;
        if (hit_o !== 1'b1) $display("FAIL accum_start_ignored: got hit=%b want 1", hit_o);
        else n_pass++;
        covered_i = 3'b101; pt_last_i = 1'b1;
        @(negedge clk);
        pt_valid_i = 1'b0; pt_last_i = 1'b0;
        n_total++;
        if (hit_o !== 1'b1) $display("FAIL accum_cfg_held: got hit=%b want 1", hit_o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done_o, count_o} !== {1'b1, 8'd2})
            $display("FAIL ignore_done: got done=%b cnt=%0d want done=1 cnt=2", done_o, count_o);
        else n_pass++;
        // Inside DONE: both a point and a start must be ignored.
        pt_valid_i = 1'b1; covered_i = 3'b111; pt_last_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; pt_valid_i = 1'b0; pt_last_i = 1'b0;
        n_total++;
        if ({hit_valid_o, busy_o, done_o, count_o} !== {3'b000, 8'd2})
            $display("FAIL done_pt_ignored: got hv=%b busy=%b done=%b cnt=%0d want 0 0 0 2", hit_valid_o, busy_o, done_o, count_o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy_o, count_o} !== {1'b0, 8'd2})
            $display("FAIL done_start_ignored: got busy=%b cnt=%0d want 0 2", busy_o, count_o);
        else n_pass++;
    endtask

    task automatic test_null_modes();
        int nz;
        f_cov.delete(); f_v.delete();
        for (int i = 0; i < 6; i++) begin f_cov.push_back(3'($urandom)); f_v.push_back(1'b1); end
        f_cov[0] = 3'b111;
        run_frame(3'd5, 3'b111, 2'd1);
        nz = 0;
        foreach (o_hit[i]) if (o_hit[i] !== 1'b0) nz++;
        n_total++;
        if (nz != 0 || o_cnt !== 8'd0) $display("FAIL mode5: got %0d hits cnt=%0d want 0", nz, o_cnt);
        else n_pass++;
        run_frame(3'd0, 3'b000, 2'd0);
        n_total++;
        if (o_cnt !== 8'd0) $display("FAIL all_mask0: got cnt=%0d want 0", o_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] md, mk;
        logic [1:0] kk;
        int n, h, bad;
        for (int f = 0; f < 25; f++) begin
            md = 3'($urandom); mk = 3'($urandom); kk = 2'($urandom);
            n = $urandom_range(1, 12);
            f_cov.delete(); f_v.delete();
            for (int i = 0; i < n; i++) begin
                f_cov.push_back(3'($urandom));
                f_v.push_back((i == n - 1) ? 1'b1 : 1'($urandom_range(0, 3) != 0));
            end
            run_frame(md, mk, kk);
            bad = 0;
            foreach (f_v[i]) begin
                if (o_hv[i] !== f_v[i]) bad++;
                else if (f_v[i] && (o_hit[i] !== model_hit(md, mk, kk, f_cov[i]))) bad++;
            end
            n_total++;
            if (bad != 0) $display("FAIL rand%0d_points: got %0d bad points want 0 (mode=%0d mask=%b k=%0d)", f, bad, md, mk, kk);
            else n_pass++;
            h = model_hits(md, mk, kk);
            n_total++;
            if ({o_lat == 2, o_cnt, o_sat} !== {1'b1, 8'(h), 1'b0})
                $display("FAIL rand%0d_count: got lat=%0d cnt=%0d sat=%b want lat=2 cnt=%0d sat=0", f, o_lat, o_cnt, o_sat, h);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_legacy_mode4();
        test_odd();
        test_saturate();
        test_ignore();
        test_null_modes();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
